online_div_sequencer: RTL

//  Master sequencer for the radix-2 signed-digit online divider. Drives STATE, cnt_master and computation_cycle to
//  the quotient-vector / SDVM / residual datapath. Paces operand-digit intake with a valid/ready handshake,

---
 rtl/online_div_pkg.sv | 25 ++
 rtl/online_div_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/online_div_pkg.sv
// Shared definitions for the radix-2 online divider: sequencer state encoding and
// default counter widths, used by the sequencer and the datapath blocks.
package online_div_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_LOAD    = 2'b01;
  localparam logic [1:0] ST_FIRST   = 2'b10;
  localparam logic [1:0] ST_COMPUTE = 2'b11;

  localparam int DEFAULT_CNT_W = 9;
  localparam int DEFAULT_CYC_W = 7;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_LOAD    = ST_LOAD,
    S_FIRST   = ST_FIRST,
    S_COMPUTE = ST_COMPUTE
  } seq_state_e;

  // FIRST and COMPUTE are the states in which an advance yields a quotient digit.
  function automatic logic emits_digit(input seq_state_e s);
    return (s == S_FIRST) || (s == S_COMPUTE);
  endfunction

endpackage

// File: rtl/online_div_sequencer.sv
// Master sequencer for the radix-2 signed-digit online divider: paces digit intake, enforces
// the online delay, flushes zero digits and reports done. ONLINE_DIV_PERF_CNT_EN adds stall_cycles.
module online_div_sequencer
  import online_div_pkg::*;
#(
  parameter int N_DIGITS = 32,
  parameter int DELTA    = 4,
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter int CYC_W    = DEFAULT_CYC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             digit_valid,
  output logic             digit_ready,
  output logic             pad_zero,
  output logic             q_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_master,
  output logic [CYC_W-1:0] computation_cycle
`ifdef ONLINE_DIV_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  if (DELTA < 1) begin : g_bad_delta
    $error("online_div_sequencer: DELTA must be >= 1");
  end
  if (N_DIGITS <= DELTA) begin : g_bad_ndigits
    $error("online_div_sequencer: N_DIGITS must exceed DELTA");
  end
  if (N_DIGITS >= (2 ** CYC_W)) begin : g_bad_cyc_w
    $error("online_div_sequencer: N_DIGITS must be below 2**CYC_W");
  end
  if ((N_DIGITS + DELTA) >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("online_div_sequencer: N_DIGITS + DELTA must be below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_N      = CNT_W'(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LOADED = CNT_W'(DELTA - 1);
  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(N_DIGITS - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             done_q, done_d;
  logic             flush_s;
  logic             advance_s;

  // Once every operand digit is consumed, zeros are padded in and the sequencer self-advances.
  assign flush_s     = (state_q == S_COMPUTE) && (cnt_q >= CNT_N);
  assign digit_ready = (state_q == S_LOAD) || (state_q == S_FIRST) ||
                       ((state_q == S_COMPUTE) && !flush_s);
  assign pad_zero    = flush_s;
  assign advance_s   = (digit_ready && digit_valid) || flush_s;
  assign q_valid     = advance_s && emits_digit(state_q);

  assign state             = state_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;
  assign cnt_master        = cnt_q;
  assign computation_cycle = cyc_q;

  // Next-state and counter update; abort overrides any advance outside IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = {CNT_W{1'b0}};
          cyc_d   = {CYC_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (advance_s) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LOADED) begin
            state_d = S_FIRST;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FIRST: begin
        if (advance_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
          cyc_d   = CYC_W'(1);
          state_d = S_COMPUTE;
        end else begin
          state_d = S_FIRST;
        end
      end
      S_COMPUTE: begin
        if (advance_s) begin
          cnt_d = cnt_q + CNT_W'(1);
          cyc_d = cyc_q + CYC_W'(1);
          if (cyc_q == CYC_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_COMPUTE;
          end
        end else begin
          state_d = S_COMPUTE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = {CNT_W{1'b0}};
      cyc_d   = {CYC_W{1'b0}};
      done_d  = 1'b0;
    end else begin
      done_d = done_d;
    end
  end

`ifdef ONLINE_DIV_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Counts ready-but-starved cycles of the current run, saturating.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = 16'h0000;
    end else if (busy && digit_ready && !digit_valid && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'h0001;
    end else begin
      stall_d = stall_q;
    end
  end

  assign stall_cycles = stall_q;
`endif

  // State, counters and done pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      cyc_q   <= {CYC_W{1'b0}};
      done_q  <= 1'b0;
`ifdef ONLINE_DIV_PERF_CNT_EN
      stall_q <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
`ifdef ONLINE_DIV_PERF_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end

endmodule
